// File: rtl/dem_tree_recombiner.sv
// Receive-side recombiner for the 1->2->4->8 DEM switching tree: rebuilds each sample
// with a pipelined adder tree and checks it against a delayed copy of the splitter input.
module dem_tree_recombiner #(
   parameter int INPUT_WIDTH  = 8,
   parameter int REF_DELAY    = 3,
   parameter int FAULT_THRESH = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          enable_i,
   input  logic                          clear_i,
   input  logic signed [INPUT_WIDTH-1:0] x_in_i,
   input  logic                          x_valid_i,
   input  logic [7:0][INPUT_WIDTH-1:0]   x_el_i,
   output logic signed [INPUT_WIDTH+2:0] sum_o,
   output logic                          sum_valid_o,
   output logic                          match_o,
   output logic                          mismatch_o,
   output logic [CNT_WIDTH-1:0]          mismatch_cnt_o,
   output logic                          fault_o,
   output logic [1:0]                    state_o
);

   localparam int W   = INPUT_WIDTH;
   localparam int DLY = REF_DELAY + 3;
   localparam logic [8:0] THRESH = 9'(FAULT_THRESH);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ALIGN = 2'b01,
      CHECK = 2'b10,
      FAULT = 2'b11
   } state_t;

   state_t         state;
   logic [W:0]     s1 [4];
   logic [W+1:0]   s2 [2];
   logic [DLY-1:0] vld_dly;
   logic [W-1:0]   ref_dly [DLY];
   logic [7:0]     run_cnt;
   logic [7:0]     align_cnt;
   logic [8:0]     run_next;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic [W+2:0]   ref_ext;
   logic           sum_eq;
   logic           cmp_en;

   // Every add sign-extends both operands by one bit, so no stage can overflow.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < 4; i++) s1[i] <= '0;
         for (int i = 0; i < 2; i++) s2[i] <= '0;
         sum_o <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            s1[i] <= {x_el_i[2*i][W-1], x_el_i[2*i]} + {x_el_i[2*i+1][W-1], x_el_i[2*i+1]};
         for (int i = 0; i < 2; i++)
            s2[i] <= {s1[2*i][W], s1[2*i]} + {s1[2*i+1][W], s1[2*i+1]};
         sum_o <= {s2[0][W+1], s2[0]} + {s2[1][W+1], s2[1]};
      end
   end

   // Reference and valid travel REF_DELAY plus the three tree stages.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         vld_dly <= '0;
         for (int i = 0; i < DLY; i++) ref_dly[i] <= '0;
      end else begin
         vld_dly    <= {vld_dly[DLY-2:0], x_valid_i};
         ref_dly[0] <= x_in_i;
         for (int i = 1; i < DLY; i++) ref_dly[i] <= ref_dly[i-1];
      end
   end

   assign sum_valid_o = vld_dly[DLY-1];
   assign ref_ext     = {{3{ref_dly[DLY-1][W-1]}}, ref_dly[DLY-1]};
   assign sum_eq      = (sum_o == ref_ext);
   // A same-cycle clear or a CHECK-state disable suppresses the compare entirely.
   assign cmp_en      = sum_valid_o && !clear_i &&
                        ((state == FAULT) || (state == CHECK && enable_i));
   assign match_o     = cmp_en && sum_eq;
   assign mismatch_o  = cmp_en && !sum_eq;
   assign state_o     = state;
   assign run_next    = {1'b0, run_cnt} + 9'd1;
   assign cnt_inc     = (&mismatch_cnt_o) ? mismatch_cnt_o : mismatch_cnt_o + CNT_WIDTH'(1);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state          <= IDLE;
         align_cnt      <= '0;
         run_cnt        <= '0;
         mismatch_cnt_o <= '0;
         fault_o        <= 1'b0;
      end else if (clear_i) begin
         state          <= enable_i ? ALIGN : IDLE;
         align_cnt      <= '0;
         run_cnt        <= '0;
         mismatch_cnt_o <= '0;
         fault_o        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable_i) begin
                  state     <= ALIGN;
                  align_cnt <= '0;
               end
            end
            ALIGN: begin
               if (!enable_i) state <= IDLE;
               else if (align_cnt == 8'(DLY - 1)) state <= CHECK;
               else align_cnt <= align_cnt + 8'd1;
            end
            CHECK: begin
               if (!enable_i) begin
                  state   <= IDLE;
                  run_cnt <= '0;
               end else if (match_o) begin
                  run_cnt <= '0;
               end else if (mismatch_o) begin
                  mismatch_cnt_o <= cnt_inc;
                  run_cnt        <= run_next[7:0];
                  if (run_next >= THRESH) begin
                     state   <= FAULT;
                     fault_o <= 1'b1;
                  end
               end
            end
            FAULT: begin
               if (mismatch_o) mismatch_cnt_o <= cnt_inc;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dem_tree_recombiner.sv
// Scoreboard bench for dem_tree_recombiner; a second instance with a 4-bit counter
// covers saturation.
module tb_dem_tree_recombiner;

   localparam int W = 8;
   typedef logic [7:0][W-1:0] el_vec_t;

   typedef struct {
      logic signed [W+2:0] sum;
      logic                exp_match;
      logic                exp_mismatch;
   } exp_t;

   logic                clk_i = 1'b0;
   logic                reset_n_i = 1'b1;
   logic                enable_i = 1'b0;
   logic                clear_i = 1'b0;
   logic                x_valid_i = 1'b0;
   logic signed [W-1:0] x_in_i = '0;
   el_vec_t             x_el_i = '0;

   logic signed [W+2:0] sum, s_sum;
   logic                sum_valid, match, mismatch, fault;
   logic                s_sum_valid, s_match, s_mismatch, s_fault;
   logic [15:0]         cnt;
   logic [3:0]          s_cnt;
   logic [1:0]          state, s_state;

   exp_t    sb [$];
   exp_t    mon_e;
   el_vec_t el_pipe [3];
   int      n_checks = 0;
   int      n_errors = 0;

   dem_tree_recombiner #(.INPUT_WIDTH(W), .REF_DELAY(3), .FAULT_THRESH(4), .CNT_WIDTH(16)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .enable_i(enable_i), .clear_i(clear_i),
      .x_in_i(x_in_i), .x_valid_i(x_valid_i), .x_el_i(x_el_i),
      .sum_o(sum), .sum_valid_o(sum_valid), .match_o(match), .mismatch_o(mismatch),
      .mismatch_cnt_o(cnt), .fault_o(fault), .state_o(state)
   );

   dem_tree_recombiner #(.INPUT_WIDTH(W), .REF_DELAY(3), .FAULT_THRESH(4), .CNT_WIDTH(4)) dut_s (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .enable_i(enable_i), .clear_i(clear_i),
      .x_in_i(x_in_i), .x_valid_i(x_valid_i), .x_el_i(x_el_i),
      .sum_o(s_sum), .sum_valid_o(s_sum_valid), .match_o(s_match), .mismatch_o(s_mismatch),
      .mismatch_cnt_o(s_cnt), .fault_o(s_fault), .state_o(s_state)
   );

   always #5 clk_i = ~clk_i;

   function automatic int el_sum(input el_vec_t el);
      int s = 0;
      for (int k = 0; k < 8; k++) s += int'($signed(el[k]));
      return s;
   endfunction

   function automatic el_vec_t rand_el();
      el_vec_t r;
      for (int k = 0; k < 8; k++) r[k] = W'($urandom_range(0, 31)) - W'(16);
      return r;
   endfunction

   function automatic el_vec_t const_el(input logic [W-1:0] v);
      el_vec_t r;
      for (int k = 0; k < 8; k++) r[k] = v;
      return r;
   endfunction

   // One input cycle: elements follow their reference by three cycles, and each valid
   // sample queues its expected sum and, when chk is set, its expected compare pulse.
   task automatic send(input logic vld, input logic signed [W-1:0] xin, input el_vec_t el,
                       input logic chk);
      exp_t e;
      x_valid_i  = vld;
      x_in_i     = xin;
      x_el_i     = el_pipe[2];
      el_pipe[2] = el_pipe[1];
      el_pipe[1] = el_pipe[0];
      el_pipe[0] = el;
      if (vld) begin
         e.sum          = (W+3)'(el_sum(el));
         e.exp_match    = chk && (e.sum == (W+3)'(int'(xin)));
         e.exp_mismatch = chk && (e.sum != (W+3)'(int'(xin)));
         sb.push_back(e);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(1'b0, '0, '0, 1'b0);
   endtask

   always @(negedge clk_i) begin
      if (reset_n_i) begin
         n_checks++;
         if (sum_valid) begin
            if (sb.size() == 0) begin
               n_errors++;
               $display("[TB] FAIL scoreboard_empty: sum=%0d valid with nothing expected", sum);
            end else begin
               mon_e = sb.pop_front();
               if (sum !== mon_e.sum || match !== mon_e.exp_match || mismatch !== mon_e.exp_mismatch) begin
                  n_errors++;
                  $display("[TB] FAIL scoreboard: sum=%0d match=%0b mismatch=%0b, expected sum=%0d match=%0b mismatch=%0b",
                           sum, match, mismatch, mon_e.sum, mon_e.exp_match, mon_e.exp_mismatch);
               end
            end
         end else if (match !== 1'b0 || mismatch !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL stray_pulse: match=%0b mismatch=%0b, expected 0 0 without sum_valid",
                     match, mismatch);
         end
      end
   end

   task automatic test_reset();
      #2 reset_n_i = 1'b0;
      #1;
      n_checks++;
      if ({sum, sum_valid, match, mismatch, cnt, fault, state, s_cnt} !== '0) begin
         n_errors++;
         $display("[TB] FAIL reset_state: sum=%0d valid=%0b cnt=%0d fault=%0b state=%0d, expected all 0",
                  sum, sum_valid, cnt, fault, state);
      end
      @(posedge clk_i);
      @(posedge clk_i);
      #1 reset_n_i = 1'b1;
   endtask

   task automatic test_sum();
      el_vec_t el;
      send(1'b1, '0, const_el(8'd5), 1'b0);
      idle(4);
      n_checks++;
      if (sum !== 11'sd0) begin
         n_errors++;
         $display("[TB] FAIL sum_latency_early: sum=%0d, expected 0 before third cycle", sum);
      end
      idle(1);
      n_checks++;
      if (sum !== 11'sd40) begin
         n_errors++;
         $display("[TB] FAIL sum_five: sum=%0d, expected 40", sum);
      end
      send(1'b1, '0, const_el(8'h80), 1'b0);
      idle(5);
      n_checks++;
      if (sum !== 11'h400) begin
         n_errors++;
         $display("[TB] FAIL sum_min: sum=%0d, expected -1024", sum);
      end
      send(1'b1, '0, const_el(8'd127), 1'b0);
      idle(5);
      n_checks++;
      if (sum !== 11'sd1016) begin
         n_errors++;
         $display("[TB] FAIL sum_max: sum=%0d, expected 1016", sum);
      end
      for (int i = 0; i < 4; i++) begin
         el = rand_el();
         el[i] = W'($urandom);
         send(1'b1, W'($urandom), el, 1'b0);
      end
      idle(6);
      n_checks++;
      if (state !== 2'b00) begin
         n_errors++;
         $display("[TB] FAIL sum_idle_state: state=%0d, expected 0", state);
      end
   endtask

   task automatic test_aligned_match();
      el_vec_t el;
      enable_i = 1'b1;
      idle(1);
      n_checks++;
      if (state !== 2'b01) begin
         n_errors++;
         $display("[TB] FAIL align_enter: state=%0d, expected 1", state);
      end
      idle(5);
      n_checks++;
      if (state !== 2'b01) begin
         n_errors++;
         $display("[TB] FAIL align_hold: state=%0d, expected 1", state);
      end
      idle(1);
      n_checks++;
      if (state !== 2'b10) begin
         n_errors++;
         $display("[TB] FAIL align_done: state=%0d, expected 2", state);
      end
      send(1'b1, 8'sd40, const_el(8'd5), 1'b1);
      for (int i = 0; i < 3; i++) begin
         el = rand_el();
         send(1'b1, W'(el_sum(el)), el, 1'b1);
      end
      idle(6);
      n_checks++;
      if (cnt !== 16'd0 || fault !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL match_count: cnt=%0d fault=%0b, expected 0 0", cnt, fault);
      end
   endtask

   task automatic send_mismatch(input logic chk);
      el_vec_t el;
      el = rand_el();
      send(1'b1, W'(el_sum(el)) ^ 8'h01, el, chk);
   endtask

   task automatic test_fault();
      for (int i = 0; i < 3; i++) send_mismatch(1'b1);
      send(1'b1, 8'sd40, const_el(8'd5), 1'b1);
      idle(6);
      n_checks++;
      if (cnt !== 16'd3 || fault !== 1'b0 || state !== 2'b10) begin
         n_errors++;
         $display("[TB] FAIL fault_run_break: cnt=%0d fault=%0b state=%0d, expected 3 0 2", cnt, fault, state);
      end
      for (int i = 0; i < 4; i++) send_mismatch(1'b1);
      idle(5);
      n_checks++;
      if (cnt !== 16'd6 || fault !== 1'b0 || state !== 2'b10) begin
         n_errors++;
         $display("[TB] FAIL fault_pre: cnt=%0d fault=%0b state=%0d, expected 6 0 2", cnt, fault, state);
      end
      idle(1);
      n_checks++;
      if (cnt !== 16'd7 || fault !== 1'b1 || state !== 2'b11) begin
         n_errors++;
         $display("[TB] FAIL fault_trip: cnt=%0d fault=%0b state=%0d, expected 7 1 3", cnt, fault, state);
      end
      enable_i = 1'b0;
      idle(3);
      n_checks++;
      if (fault !== 1'b1 || state !== 2'b11) begin
         n_errors++;
         $display("[TB] FAIL fault_sticky: fault=%0b state=%0d, expected 1 3", fault, state);
      end
   endtask

   task automatic test_clear();
      enable_i = 1'b1;
      clear_i  = 1'b1;
      idle(1);
      clear_i  = 1'b0;
      n_checks++;
      if (cnt !== 16'd0 || fault !== 1'b0 || state !== 2'b01) begin
         n_errors++;
         $display("[TB] FAIL clear_fault: cnt=%0d fault=%0b state=%0d, expected 0 0 1", cnt, fault, state);
      end
      idle(5);
      n_checks++;
      if (state !== 2'b01) begin
         n_errors++;
         $display("[TB] FAIL clear_align_hold: state=%0d, expected 1", state);
      end
      idle(1);
      n_checks++;
      if (state !== 2'b10) begin
         n_errors++;
         $display("[TB] FAIL clear_realign: state=%0d, expected 2", state);
      end
      // Clear lands in the exact cycle this mismatch reaches the comparator.
      send_mismatch(1'b0);
      idle(5);
      clear_i = 1'b1;
      idle(1);
      clear_i = 1'b0;
      n_checks++;
      if (cnt !== 16'd0 || state !== 2'b01) begin
         n_errors++;
         $display("[TB] FAIL clear_priority: cnt=%0d state=%0d, expected 0 1", cnt, state);
      end
      idle(6);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) send_mismatch(1'b1);
      idle(6);
      n_checks++;
      if (s_cnt !== 4'd15) begin
         n_errors++;
         $display("[TB] FAIL saturation_small: cnt=%0d, expected 15", s_cnt);
      end
      n_checks++;
      if (cnt !== 16'd20 || fault !== 1'b1 || state !== 2'b11) begin
         n_errors++;
         $display("[TB] FAIL saturation_wide: cnt=%0d fault=%0b state=%0d, expected 20 1 3", cnt, fault, state);
      end
   endtask

   task automatic test_reset_mid();
      send(1'b1, 8'sd40, const_el(8'd5), 1'b1);
      idle(5);
      n_checks++;
      if (sum !== 11'sd40 || sum_valid !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL reset_mid_pre: sum=%0d valid=%0b, expected 40 1", sum, sum_valid);
      end
      #2 reset_n_i = 1'b0;
      #1;
      sb.delete();
      n_checks++;
      if ({sum, sum_valid, match, mismatch, cnt, fault, state, s_cnt} !== '0) begin
         n_errors++;
         $display("[TB] FAIL reset_mid_async: sum=%0d valid=%0b cnt=%0d fault=%0b state=%0d, expected all 0",
                  sum, sum_valid, cnt, fault, state);
      end
      x_valid_i = 1'b1;
      x_in_i    = 8'sd40;
      x_el_i    = const_el(8'd5);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i);
         #1;
         n_checks++;
         if ({sum, sum_valid, match, mismatch, cnt, fault, state} !== '0) begin
            n_errors++;
            $display("[TB] FAIL reset_mid_hold: sum=%0d valid=%0b state=%0d, expected all 0",
                     sum, sum_valid, state);
         end
      end
      for (int i = 0; i < 3; i++) el_pipe[i] = '0;
      x_valid_i = 1'b0;
      x_el_i    = '0;
      reset_n_i = 1'b1;
      idle(1);
      n_checks++;
      if (state !== 2'b01 || cnt !== 16'd0 || fault !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL reset_release: state=%0d cnt=%0d fault=%0b, expected 1 0 0", state, cnt, fault);
      end
      idle(7);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) el_pipe[i] = '0;
      test_reset();
      test_sum();
      test_aligned_match();
      test_fault();
      test_clear();
      test_saturation();
      test_reset_mid();
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation still running at %0t, expected to finish", $time);
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/dem_tree_recombiner.md
Name: dem_tree_recombiner

Overview:
- Receive side of the 3-layer DEM switching tree: takes the 8 unit-element codes produced by the 1->2->4->8 splitter and rebuilds the original sample with a pipelined 8->4->2->1 adder tree.
- Checks each rebuilt sample against a delayed copy of the splitter input. Counts mismatches and raises a sticky fault on a run of consecutive errors.
- Sits beside the switching tree as an on-chip self-check and monitor.

Parameters:
INPUT_WIDTH, 8 (lib_switchblock_pkg value), width of splitter input and of each element code, signed
REF_DELAY, 3, cycles from x_in_i/x_valid_i to the matching element codes at x_el_i
FAULT_THRESH, 4, consecutive mismatches that trigger FAULT (range 1..255)
CNT_WIDTH, 16, width of the mismatch counter

Ports:
clk_i  in  1  clock, all logic on rising edge
reset_n_i  in  1  reset, asynchronous, active-low
enable_i  in  1  level; 1 = checking enabled
clear_i  in  1  1-cycle pulse; clears counters and fault
x_in_i  in  INPUT_WIDTH  signed splitter input sample
x_valid_i  in  1  qualifies x_in_i
x_el_i  in  8 x INPUT_WIDTH  signed element codes, index 0..7
sum_o  out  INPUT_WIDTH+3  signed reconstructed sample
sum_valid_o  out  1  qualifies sum_o
match_o  out  1  1-cycle pulse: compared sample equal
mismatch_o  out  1  1-cycle pulse: compared sample differs
mismatch_cnt_o  out  CNT_WIDTH  saturating mismatch count
fault_o  out  1  sticky fault flag
state_o  out  2  FSM state: 00 IDLE, 01 ALIGN, 10 CHECK, 11 FAULT

Behaviour:
Reset
- reset_n_i low clears all outputs, pipeline registers, delay lines and counters to 0 immediately, without waiting for a clock edge.
- State goes to IDLE.

Adder tree
- Stage 1 registers 4 pair sums at W+1 bits. Stage 2 registers 2 sums at W+2. Stage 3 registers 1 sum at W+3.
- All additions sign-extend their operands, so no overflow is possible.
- Latency: 3 cycles from x_el_i to sum_o. The tree runs in every state except under reset.

Valid and reference alignment
- x_valid_i is delayed REF_DELAY+3 cycles to form sum_valid_o.
- x_in_i is delayed REF_DELAY+3 cycles in the same way and sign-extended to W+3 bits to form the compare reference.
- A compare happens only when sum_valid_o=1.

FSM
- IDLE: no compares. enable_i=1 -> ALIGN.
- ALIGN: no compares. Counts REF_DELAY+3 cycles to flush the pipelines, then -> CHECK. enable_i=0 -> IDLE.
- CHECK: each qualified compare pulses match_o or mismatch_o in the cycle sum_valid_o is high.
  - A mismatch increments mismatch_cnt_o and a run counter.
  - A match zeroes the run counter.
  - Run counter reaching FAULT_THRESH -> FAULT, with fault_o=1 from the next cycle. enable_i=0 -> IDLE; the run counter is zeroed and mismatch_cnt_o is held.
- FAULT: fault_o is held at 1 and compares continue. Mismatches still increment mismatch_cnt_o. enable_i has no effect; only clear_i or reset leaves this state.

clear_i
- In any state, clears mismatch_cnt_o, the run counter and fault_o.
- Next state is ALIGN if enable_i=1, else IDLE.
- clear_i has priority over a same-cycle mismatch; that compare is neither pulsed nor counted.

Counter and sum boundaries
- mismatch_cnt_o saturates at all-ones and never wraps.
- Element sum range at W=8: -1024..+1016 in 11 bits.

Test Plan:
- Reset: drive reset_n_i low mid-stream -> all outputs 0 and state_o=00 immediately; no output moves until after release.
- Sum: all x_el_i=5 for 1 cycle -> sum_o=40 exactly 3 cycles later. All elements -128 -> sum_o=-1024 (11'h400). All elements +127 -> sum_o=+1016.
- Aligned check: enable_i=1, wait 6 cycles -> state_o=10. Drive x_in_i=40 with x_valid_i, then all elements=5 three cycles later -> match_o pulses and mismatch_cnt_o stays 0.
- Fault: in CHECK, inject 3 mismatches then 1 match -> mismatch_cnt_o=3, fault_o=0. Then inject 4 consecutive mismatches -> fault_o=1 and state_o=11 after the 4th, mismatch_cnt_o=7. Drop enable_i -> state stays 11.
- Clear: pulse clear_i in FAULT with enable_i=1 -> mismatch_cnt_o=0, fault_o=0, state_o=01, back to 10 after 6 cycles. Pulse clear_i in the same cycle as a mismatch -> no mismatch_o and count stays 0.
- Saturation: with CNT_WIDTH=4, force 20 mismatches -> mismatch_cnt_o holds at 15.
